count_peak_logger: RTL and testbench

Downstream monitor for the 4-bit up counter's `out` bus. It samples the count stream, detects every downward jump (wrap, compare-reset, or downward load), and logs the peak value reached before each drop into a small FIFO. Consumers drain the FIFO through a valid/ready handshake. The block also flags a stalled counter (select = hold) and keeps a saturating wrap total.

---
 rtl/count_peak_logger_pkg.sv | 26 ++
 rtl/count_peak_logger_if.sv | 43 ++++
 rtl/count_peak_logger_fifo.sv | 95 +++++++++
 rtl/count_peak_logger.sv | 107 ++++++++++
 tb/tb_count_peak_logger.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/count_peak_logger_pkg.sv
//============================================================================
// Module      : count_pkg
// Description : Shared constants and helpers for the count peak logger.
//               COUNT_W matches the upstream counter output width; the wrap
//               total is a saturating 8-bit event counter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package count_pkg;

    localparam int COUNT_W        = 4;
    localparam int WRAP_TOTAL_W   = 8;
    localparam int WRAP_TOTAL_MAX = 255;

    // Saturating increment for the wrap total: sticks at WRAP_TOTAL_MAX.
    function automatic logic [WRAP_TOTAL_W-1:0] sat_inc(input logic [WRAP_TOTAL_W-1:0] v);
        if (v == WRAP_TOTAL_W'(WRAP_TOTAL_MAX)) begin
            return v;
        end
        return v + WRAP_TOTAL_W'(1);
    endfunction

endpackage : count_pkg

`default_nettype wire

// File: rtl/count_peak_logger_if.sv
//============================================================================
// Module      : count_peak_logger_if
// Description : Bundles the count sample input, the peak FIFO valid/ready
//               drain port and the status outputs of the peak logger.
//               master : the environment (drives samples, accepts peaks)
//               slave  : the logger itself
// Ports       : count_in/count_en   - sample stream
//               peak_data/valid/ready - FWFT FIFO drain handshake
//               fifo_level, overflow, stall, wrap_total - status
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface count_peak_logger_if
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_W,
    parameter int DEPTH = 4
);

    logic [WIDTH-1:0]          count_in;
    logic                      count_en;
    logic [WIDTH-1:0]          peak_data;
    logic                      peak_valid;
    logic                      peak_ready;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic                      overflow;
    logic                      stall;
    logic [WRAP_TOTAL_W-1:0]   wrap_total;

    modport master (
        output count_in, count_en, peak_ready,
        input  peak_data, peak_valid, fifo_level, overflow, stall, wrap_total
    );

    modport slave (
        input  count_in, count_en, peak_ready,
        output peak_data, peak_valid, fifo_level, overflow, stall, wrap_total
    );

endinterface : count_peak_logger_if

`default_nettype wire

// File: rtl/count_peak_logger_fifo.sv
//============================================================================
// Module      : peak_fifo
// Description : First-word fall-through FIFO for logged peaks. Pointers wrap
//               modulo DEPTH; a separate level counter tells full from empty.
//               A push into a full FIFO is accepted only if a pop happens in
//               the same cycle, otherwise it is dropped and o_drop pulses.
// Ports       : clk, clear (async, active-high)
//               i_push/i_push_data - write side
//               i_pop_ready        - consumer ready; pop = valid & ready
//               o_data/o_valid     - head of queue
//               o_level            - occupancy 0..DEPTH
//               o_drop             - combinational: push lost to full FIFO
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module peak_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   clear,
    input  wire logic                   i_push,
    input  wire logic [WIDTH-1:0]       i_push_data,
    input  wire logic                   i_pop_ready,
    output logic      [WIDTH-1:0]       o_data,
    output logic                        o_valid,
    output logic      [$clog2(DEPTH):0] o_level,
    output logic                        o_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] c_full_level = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [LVL_W-1:0] r_level_q,  w_level_d;

    logic w_full;
    logic w_pop;
    logic w_accept;

    assign o_valid = (r_level_q != '0);
    assign o_level = r_level_q;
    // Head is forced to zero while empty so the idle/reset value is defined.
    assign o_data  = o_valid ? r_mem_q[r_rd_ptr_q] : '0;

    assign w_full   = (r_level_q == c_full_level);
    assign w_pop    = o_valid && i_pop_ready;
    // When full, the slot being written is the one being popped this cycle.
    assign w_accept = i_push && (!w_full || w_pop);
    assign o_drop   = i_push && w_full && !w_pop;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_accept) begin
            w_mem_d[r_wr_ptr_q] = i_push_data;
            w_wr_ptr_d          = r_wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
        end
        case ({w_accept, w_pop})
            2'b10:   w_level_d = r_level_q + LVL_W'(1);
            2'b01:   w_level_d = r_level_q - LVL_W'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    // Storage needs no reset: contents are only visible while o_valid is set.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

endmodule : peak_fifo

`default_nettype wire

// File: rtl/count_peak_logger.sv
//============================================================================
// Module      : count_peak_logger
// Description : Watches a counter's output stream, detects every downward
//               jump and logs the value held just before the drop into a
//               small FWFT FIFO. Also flags a stalled counter and keeps a
//               saturating count of drops.
// Ports       : clk   - clock
//               clear - asynchronous active-high reset
//               bus   - count_peak_logger_if.slave (samples, peak drain,
//                       fifo_level, overflow, stall, wrap_total)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module count_peak_logger
    import count_pkg::*;
#(
    parameter int WIDTH       = COUNT_W,
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 8
) (
    input  wire logic            clk,
    input  wire logic            clear,
    count_peak_logger_if.slave   bus
);

    localparam int HR_W = $clog2(STALL_LIMIT + 1);
    localparam logic [HR_W-1:0] c_stall_limit = HR_W'(STALL_LIMIT);

    logic [WIDTH-1:0]        r_prev_q,     w_prev_d;
    logic                    r_prev_vld_q, w_prev_vld_d;
    logic [HR_W-1:0]         r_hold_run_q, w_hold_run_d;
    logic [WRAP_TOTAL_W-1:0] r_wrap_q,     w_wrap_d;
    logic                    r_ovf_q,      w_ovf_d;

    logic w_drop_evt;
    logic w_equal;
    logic w_fifo_drop;

    // The very first sample after clear only seeds r_prev_q.
    assign w_drop_evt = bus.count_en && r_prev_vld_q && (bus.count_in <  r_prev_q);
    assign w_equal    = bus.count_en && r_prev_vld_q && (bus.count_in == r_prev_q);

    always_comb begin
        w_prev_d     = r_prev_q;
        w_prev_vld_d = r_prev_vld_q;
        w_hold_run_d = r_hold_run_q;
        w_wrap_d     = r_wrap_q;
        w_ovf_d      = r_ovf_q;
        if (bus.count_en) begin
            w_prev_d     = bus.count_in;
            w_prev_vld_d = 1'b1;
            if (w_equal) begin
                if (r_hold_run_q != c_stall_limit) begin
                    w_hold_run_d = r_hold_run_q + HR_W'(1);
                end
            end else begin
                w_hold_run_d = '0;
            end
        end
        // Drops still count even when the FIFO had to discard the entry.
        if (w_drop_evt) begin
            w_wrap_d = sat_inc(r_wrap_q);
        end
        if (w_fifo_drop) begin
            w_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_prev_q     <= '0;
            r_prev_vld_q <= 1'b0;
            r_hold_run_q <= '0;
            r_wrap_q     <= '0;
            r_ovf_q      <= 1'b0;
        end else begin
            r_prev_q     <= w_prev_d;
            r_prev_vld_q <= w_prev_vld_d;
            r_hold_run_q <= w_hold_run_d;
            r_wrap_q     <= w_wrap_d;
            r_ovf_q      <= w_ovf_d;
        end
    end

    assign bus.stall      = (r_hold_run_q == c_stall_limit);
    assign bus.wrap_total = r_wrap_q;
    assign bus.overflow   = r_ovf_q;

    peak_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_peak_fifo (
        .clk         (clk),
        .clear       (clear),
        .i_push      (w_drop_evt),
        .i_push_data (r_prev_q),
        .i_pop_ready (bus.peak_ready),
        .o_data      (bus.peak_data),
        .o_valid     (bus.peak_valid),
        .o_level     (bus.fifo_level),
        .o_drop      (w_fifo_drop)
    );

endmodule : count_peak_logger

`default_nettype wire

// File: tb/tb_count_peak_logger.sv
//============================================================================
// Module      : tb_count_peak_logger
// Description : Directed bench for count_peak_logger. Expected peaks are
//               queued as stimulus is issued; a monitor on the falling edge
//               compares each handshaken FIFO head against the queue.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_count_peak_logger;
    import count_pkg::*;

    localparam int WIDTH       = 4;
    localparam int DEPTH       = 4;
    localparam int STALL_LIMIT = 8;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    count_peak_logger_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    count_peak_logger #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int mon_exp;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a pop happens at the next rising edge whenever
    // valid and ready are both high here.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.peak_valid && bus.peak_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fifo_head: got %0d, expected no entry", bus.peak_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (int'(bus.peak_data) != mon_exp) begin
                        n_err++;
                        $display("FAIL fifo_head: got %0d, expected %0d", bus.peak_data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sample(input int v);
        bus.count_in = WIDTH'(v);
        bus.count_en = 1'b1;
        @(posedge clk);
        #1;
        bus.count_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        clear = 1'b1;
        @(posedge clk);
        #3;
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        bus.peak_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        bus.peak_ready = 1'b0;
        chk({name, "_level_after_drain"}, int'(bus.fifo_level), 0);
        chk({name, "_valid_after_drain"}, int'(bus.peak_valid), 0);
    endtask

    initial begin
        clear          = 1'b1;
        bus.count_in   = '0;
        bus.count_en   = 1'b0;
        bus.peak_ready = 1'b0;
        #12;
        chk("rst_peak_data",  int'(bus.peak_data),  0);
        chk("rst_peak_valid", int'(bus.peak_valid), 0);
        chk("rst_level",      int'(bus.fifo_level), 0);
        chk("rst_overflow",   int'(bus.overflow),   0);
        chk("rst_stall",      int'(bus.stall),      0);
        chk("rst_wrap_total", int'(bus.wrap_total), 0);
        @(posedge clk);
        #3;
        clear = 1'b0;

        // Free-running wrap: 0..15,0,1 logs a single peak of 15.
        for (int v = 0; v < 16; v++) sample(v);
        sample(0);
        exp_q.push_back(15);
        chk("free_valid", int'(bus.peak_valid), 1);
        chk("free_data",  int'(bus.peak_data),  15);
        sample(1);
        chk("free_level", int'(bus.fifo_level), 1);
        chk("free_wrap",  int'(bus.wrap_total), 1);
        drain("free");

        // Compare-reset at 6, then an upward load to 9 followed by 3.
        do_reset();
        for (int v = 0; v <= 6; v++) sample(v);
        sample(0);
        exp_q.push_back(6);
        sample(9);
        sample(3);
        exp_q.push_back(9);
        chk("cmp_level", int'(bus.fifo_level), 2);
        chk("cmp_wrap",  int'(bus.wrap_total), 2);
        drain("cmp");

        // Stall detection: seed 5, then eight equal samples.
        do_reset();
        sample(5);
        for (int i = 1; i <= STALL_LIMIT; i++) begin
            sample(5);
            if (i == STALL_LIMIT - 1) chk("stall_before_limit", int'(bus.stall), 0);
            if (i == STALL_LIMIT)     chk("stall_at_limit",     int'(bus.stall), 1);
        end
        sample(6);
        chk("stall_release", int'(bus.stall),      0);
        chk("stall_wrap",    int'(bus.wrap_total), 0);
        chk("stall_level",   int'(bus.fifo_level), 0);

        // Overflow: five drops into a four-entry FIFO, peak 7 is lost.
        do_reset();
        for (int p = 3; p <= 7; p++) begin
            sample(p);
            sample(0);
            if (p <= 6) exp_q.push_back(p);
        end
        chk("ovf_level",    int'(bus.fifo_level), 4);
        chk("ovf_flag",     int'(bus.overflow),   1);
        chk("ovf_wrap",     int'(bus.wrap_total), 5);
        chk("ovf_head",     int'(bus.peak_data),  3);
        drain("ovf");
        chk("ovf_sticky",   int'(bus.overflow),   1);

        // Full FIFO with a pop in the same cycle as the push.
        do_reset();
        for (int p = 1; p <= 4; p++) begin
            sample(p);
            sample(0);
            exp_q.push_back(p);
        end
        sample(9);
        chk("fullpp_level_before", int'(bus.fifo_level), 4);
        bus.peak_ready = 1'b1;
        exp_q.push_back(9);
        sample(2);
        bus.peak_ready = 1'b0;
        chk("fullpp_level",    int'(bus.fifo_level), 4);
        chk("fullpp_overflow", int'(bus.overflow),   0);
        chk("fullpp_wrap",     int'(bus.wrap_total), 5);
        drain("fullpp");

        // Asynchronous clear with two entries queued and prev left at 5.
        do_reset();
        sample(2); sample(0);
        sample(3); sample(0);
        sample(5);
        chk("clr_level_before", int'(bus.fifo_level), 2);
        #2;
        clear = 1'b1;
        #1;
        chk("clr_valid_async", int'(bus.peak_valid), 0);
        chk("clr_level_async", int'(bus.fifo_level), 0);
        chk("clr_wrap_async",  int'(bus.wrap_total), 0);
        exp_q.delete();
        #1;
        clear = 1'b0;
        sample(0);
        chk("clr_first_valid", int'(bus.peak_valid), 0);
        chk("clr_first_wrap",  int'(bus.wrap_total), 0);

        repeat (2) @(posedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_count_peak_logger

`default_nettype wire
